// File: rtl/sprite_fetch_arbiter.sv
// sprite_fetch_arbiter: round-robin sharing of one character-sprite ROM between two
// pixel-fetch requesters. Registers ROM select/address, tracks in-flight fetches in a
// tag pipeline of depth 1+ROM_LAT, and steers each returned pixel to its issuer.
// Optional macro SPRITE_FETCH_HFLIP_EN adds per-requester horizontal-flip inputs that
// mirror the column bits of the pixel address.
module sprite_fetch_arbiter #(
  parameter int unsigned CHAR_W    = 4,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 6,
  parameter int unsigned ROM_LAT   = 0,
  parameter int unsigned NUM_CHARS = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [CHAR_W-1:0] req0_char,
  input  logic [ADDR_W-1:0] req0_addr,
`ifdef SPRITE_FETCH_HFLIP_EN
  input  logic              req0_flip,
`endif
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [CHAR_W-1:0] req1_char,
  input  logic [ADDR_W-1:0] req1_addr,
`ifdef SPRITE_FETCH_HFLIP_EN
  input  logic              req1_flip,
`endif
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [CHAR_W-1:0] rom_char,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              bad_char
);

  localparam int unsigned Depth = 1 + ROM_LAT;

  // 0: requester 0 wins a tie, 1: requester 1 wins a tie
  logic ptr_q;

  logic              grant0;
  logic              grant1;
  logic              accept;
  logic              sel_id;
  logic [CHAR_W-1:0] sel_char;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_bad;

  logic [Depth-1:0] tag_valid_q;
  logic [Depth-1:0] tag_id_q;

  logic tail_valid;
  logic tail_id;

  // Grant depends only on the two valids, the pointer and reset
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (req0_valid && (!req1_valid || !ptr_q)) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;

  // Select the granted request, sanitise the char code and apply the optional mirror
  always_comb begin
    sel_id   = grant1;
    sel_char = grant1 ? req1_char : req0_char;
    sel_addr = grant1 ? req1_addr : req0_addr;
`ifdef SPRITE_FETCH_HFLIP_EN
    if (grant1 ? req1_flip : req0_flip) begin
      // mirror the column inside the 64-wide sprite row
      sel_addr = {sel_addr[ADDR_W-1:6], ~sel_addr[5:0]};
    end
`endif
    sel_bad = 32'(sel_char) >= NUM_CHARS;
    if (sel_bad) begin
      sel_char = '0;
    end
  end

  // Round-robin pointer: after a grant, favour the requester that did not win
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (accept) begin
      ptr_q <= grant0;
    end
  end

  // ROM select/address registers hold when nothing is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_char <= '0;
      rom_addr <= '0;
      bad_char <= 1'b0;
    end else begin
      bad_char <= accept & sel_bad;
      if (accept) begin
        rom_char <= sel_char;
        rom_addr <= sel_addr;
      end
    end
  end

  // Tag pipeline tracks which requester owns each in-flight fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid_q <= '0;
      tag_id_q    <= '0;
    end else begin
      tag_valid_q[0] <= accept;
      tag_id_q[0]    <= sel_id;
      for (int i = 1; i < int'(Depth); i++) begin
        tag_valid_q[i] <= tag_valid_q[i-1];
        tag_id_q[i]    <= tag_id_q[i-1];
      end
    end
  end

  assign tail_valid = tag_valid_q[Depth-1];
  assign tail_id    = tag_id_q[Depth-1];

  // Capture the ROM pixel as the oldest tag leaves and pulse the owner's valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
    end else begin
      rsp0_valid <= tail_valid & ~tail_id;
      rsp1_valid <= tail_valid & tail_id;
      if (tail_valid && !tail_id) begin
        rsp0_data <= rom_data;
      end
      if (tail_valid && tail_id) begin
        rsp1_data <= rom_data;
      end
    end
  end

endmodule
